online_checker_r4: RTL
======================

# online_checker_r4

Serial result checker for the radix-4 online adder test bench. It consumes the adder's output digit stream, most-significant digit first, with a valid strobe. It compares that stream against the expected parallel result vector produced by the team's test-vector generator, then reports pass/fail, mismatch statistics and protocol faults. It sits between the adder under test and the bench controller, and it is the sink end of the stimulus path.

## Interface
- `N`, default 6: operand digit count; the result has N+1 digits.
- `C`, default 3: bits per digit, two's complement; legal digit set is {-3..3}.
- `TIMEOUT`, default 64: maximum idle cycles between accepted digits while running.
- `clk`, in, 1: single clock; all logic is rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle pulse that latches `z_exp` and arms the checker.
- `z_exp`, in, (N+1)*C: expected result, MSD in the top C bits.
- `dig_valid`, in, 1: `dig_in` carries a result digit this cycle.
- `dig_in`, in, C: result digit from the adder.
- `busy`, out, 1: checker is in RUN or REPORT.
- `done`, out, 1: one-cycle pulse in REPORT.
- `pass`, out, 1: verdict; held until the next accepted `start`.
- `mismatch_cnt`, out, $clog2(N+2): number of digit positions that differ.
- `first_mismatch`, out, $clog2(N+1): index (0 = MSD) of the first differing digit; 0 if none.
- `illegal`, out, 1: a received digit equalled 3'b100 (-4).
- `timeout`, out, 1: run aborted by the idle timer.
- `overrun`, out, 1: sticky flag; `dig_valid` was seen while IDLE. Cleared by reset or `start`.

## Operation
- Reset: state IDLE. All outputs 0, counters 0, expected shift register 0.
- IDLE:
  - `start` → RUN. Latch `z_exp` into the shift register; clear `pass`, `mismatch_cnt`, `first_mismatch`, `illegal`, `timeout` and `overrun`.
  - `dig_valid` → set `overrun`; the digit is discarded.
- RUN: each cycle with `dig_valid`:
  - Compare `dig_in` with the top digit of the shift register, then shift left by C.
  - On a differing digit: increment `mismatch_cnt`. Load `first_mismatch` with the digit index if this is the first difference.
  - `dig_in`==3'b100 → set `illegal`.
  - Increment the digit index and reset the idle timer.
- RUN, cycle without `dig_valid`: increment the idle timer. When the timer reaches TIMEOUT → REPORT with `timeout`=1.
- RUN exit: the (N+1)th accepted digit → REPORT.
- REPORT (one cycle):
  - `done`=1. `pass` = verdict & !`illegal` & !`timeout`.
  - Next state IDLE.
- `start` in RUN or REPORT is ignored.
- `dig_valid` in REPORT is ignored and does not set `overrun`.
- Reset in any state returns to IDLE with reset values on the next edge. No `done` pulse is produced.

## Timing
- `start` sampled at edge t: `busy`=1 from t+1. The first digit is accepted at edge t+1 or later; a digit coincident with `start` is not accepted.
- Last digit accepted at edge k: `done`, `pass` and all statistics are valid in cycle k+1. `busy`=0 from k+2.
- Minimum run is N+2 cycles from `start` to `done`.
- Timeout: `done` occurs TIMEOUT+1 cycles after the last accepted digit, or after `start` if no digit arrives.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `CHECKER_VALUE_CMP_EN` defined: the block adds two value accumulators, acc = 4·acc + sext(d), each 2(N+1)+1 bits signed.
  - One accumulator takes the received digits; the other takes the digits shifted out of the expected register.
  - Verdict = (received value == expected value). Redundant representations of the same value pass. `mismatch_cnt` is still reported.
- Not defined: verdict = (`mismatch_cnt`==0). The accumulators are not built.

## Structure
- Package `online_r4_pkg` holds:
  - digit width constant and the `DIGIT_ILLEGAL` (3'b100) constant;
  - state enum {IDLE, RUN, REPORT};
  - digit sign-extension function.
- Sub-module `r4_value_acc` is a serial MSD-first radix-4 to two's complement accumulator with clear and enable inputs. It is instantiated twice, only under `CHECKER_VALUE_CMP_EN`.

## Test plan
- `z_exp`={1,-1,0,-1,2,2,1}; feed the same 7 digits back-to-back → `done` at cycle 8 after `start`, `pass`=1, `mismatch_cnt`=0.
- Same `z_exp`; feed {0,3,0,-1,2,2,1}:
  - with the macro → `pass`=1, `mismatch_cnt`=2, `first_mismatch`=0;
  - without the macro → `pass`=0.
- Same `z_exp`; digit 3 is 3'b100 → `illegal`=1, `pass`=0.
- `z_exp`=0; feed 3 zero digits, then stop → `done` 65 cycles after the third digit, `timeout`=1, `pass`=0.
- Pulse `dig_valid` while IDLE → `overrun`=1. A following `start` clears it. Reset asserted mid-run → IDLE with all outputs 0 and no `done` pulse.
- `z_exp`=0; all-zero digits with `dig_valid` gaps of 10 cycles → `pass`=1, no timeout.

Source files
------------

// File: rtl/online_r4_pkg.sv
// Shared types and constants for the radix-4 online result checker.
// Digits are signed two's complement in the set {-3..3}; -4 is reserved as illegal.
package online_r4_pkg;

    localparam int unsigned DigitWidth = 3;
    localparam logic [DigitWidth-1:0] DIGIT_ILLEGAL = 3'b100;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StReport
    } state_e;

    function automatic logic signed [31:0] digit_sext(input logic [DigitWidth-1:0] d);
        return 32'(signed'(d));
    endfunction

endpackage

// File: rtl/r4_value_acc.sv
// Serial MSD-first radix-4 signed-digit to two's complement accumulator.
// Each enabled cycle computes acc = 4*acc + sext(digit); clear has priority over enable.
module r4_value_acc
    import online_r4_pkg::*;
#(
    parameter int unsigned W = 15
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic [DigitWidth-1:0]  dig_i,
    output logic signed [W-1:0]    value_nxt_o
);

    logic signed [W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (en_i) begin
            value_d = {value_q[W-3:0], 2'b00} + W'(digit_sext(dig_i));
        end
    end

    // The next value is exported so the verdict can include the digit accepted this edge.
    assign value_nxt_o = value_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/online_checker_r4.sv
// Serial result checker for a radix-4 online adder: compares the MSD-first digit stream
// against an expected vector. Define CHECKER_VALUE_CMP_EN for a value-based verdict.
module online_checker_r4
    import online_r4_pkg::*;
#(
    parameter int unsigned N       = 6,
    parameter int unsigned C       = DigitWidth,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [(N+1)*C-1:0]       z_exp,
    input  logic                     dig_valid,
    input  logic [C-1:0]             dig_in,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [$clog2(N+2)-1:0]   mismatch_cnt,
    output logic [$clog2(N+1)-1:0]   first_mismatch,
    output logic                     illegal,
    output logic                     timeout,
    output logic                     overrun
);

    localparam int unsigned ZW   = (N + 1) * C;
    localparam int unsigned CntW = $clog2(N + 2);
    localparam int unsigned IdxW = $clog2(N + 1);
    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [ZW-1:0]     exp_q, exp_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic [CntW-1:0]   mm_cnt_q, mm_cnt_d;
    logic [IdxW-1:0]   first_q, first_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    logic              overrun_q, overrun_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [C-1:0]      exp_top;
    logic              start_acc;
    logic              accept;
    logic              last_dig;
    logic              expire;
    logic              verdict;

    assign exp_top   = exp_q[ZW-1 -: C];
    assign start_acc = (state_q == StIdle) && start;
    assign accept    = (state_q == StRun) && dig_valid;
    assign last_dig  = accept && (idx_q == IdxW'(N));
    assign expire    = (state_q == StRun) && !dig_valid && (tmr_q == TmrW'(TIMEOUT - 1));

`ifdef CHECKER_VALUE_CMP_EN
    localparam int unsigned AccW = 2 * (N + 1) + 1;

    logic signed [AccW-1:0] rx_val_nxt;
    logic signed [AccW-1:0] ex_val_nxt;

    r4_value_acc #(
        .W (AccW)
    ) u_rx_acc (
        .clk_i       (clk),
        .reset_i     (reset),
        .clr_i       (start_acc),
        .en_i        (accept),
        .dig_i       (dig_in),
        .value_nxt_o (rx_val_nxt)
    );

    r4_value_acc #(
        .W (AccW)
    ) u_ex_acc (
        .clk_i       (clk),
        .reset_i     (reset),
        .clr_i       (start_acc),
        .en_i        (accept),
        .dig_i       (exp_top),
        .value_nxt_o (ex_val_nxt)
    );

    // Redundant digit strings of equal value are accepted.
    assign verdict = (rx_val_nxt == ex_val_nxt);
`else
    assign verdict = (mm_cnt_d == '0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                if (last_dig || expire) state_d = StReport;
            end
            StReport: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        exp_d     = exp_q;
        idx_d     = idx_q;
        tmr_d     = tmr_q;
        mm_cnt_d  = mm_cnt_q;
        first_d   = first_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q;
        pass_d    = pass_q;

        if (state_q == StIdle) begin
            if (start) begin
                exp_d     = z_exp;
                idx_d     = '0;
                tmr_d     = '0;
                mm_cnt_d  = '0;
                first_d   = '0;
                illegal_d = 1'b0;
                timeout_d = 1'b0;
                overrun_d = 1'b0;
                pass_d    = 1'b0;
            end else if (dig_valid) begin
                overrun_d = 1'b1;
            end
        end

        if (accept) begin
            if (dig_in != exp_top) begin
                mm_cnt_d = mm_cnt_q + CntW'(1);
                if (mm_cnt_q == '0) first_d = idx_q;
            end
            if (dig_in == DIGIT_ILLEGAL) illegal_d = 1'b1;
            exp_d = {exp_q[ZW-C-1:0], {C{1'b0}}};
            idx_d = idx_q + IdxW'(1);
            tmr_d = '0;
        end else if (state_q == StRun) begin
            tmr_d = tmr_q + TmrW'(1);
            if (expire) timeout_d = 1'b1;
        end

        // Verdict is latched on the edge entering REPORT so it is valid alongside done.
        if (state_d == StReport) begin
            pass_d = verdict && !illegal_d && !timeout_d;
        end

        done_d = (state_d == StReport);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q     <= '0;
            idx_q     <= '0;
            tmr_q     <= '0;
            mm_cnt_q  <= '0;
            first_q   <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            pass_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            exp_q     <= exp_d;
            idx_q     <= idx_d;
            tmr_q     <= tmr_d;
            mm_cnt_q  <= mm_cnt_d;
            first_q   <= first_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
            pass_q    <= pass_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign mismatch_cnt   = mm_cnt_q;
    assign first_mismatch = first_q;
    assign illegal        = illegal_q;
    assign timeout        = timeout_q;
    assign overrun        = overrun_q;

endmodule
